// File: rtl/act_ser_pkg.sv
// Shared widths, beat/count types and buffer depth for the activation output serializer.
package act_ser_pkg;
  localparam int IN_W_DEF  = 2048;
  localparam int OUT_W_DEF = 64;
  localparam int BEATS     = IN_W_DEF / OUT_W_DEF;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [BEAT_W-1:0] beat_idx_t;
  typedef logic [1:0]        buf_cnt_t;

  localparam buf_cnt_t BUF_DEPTH = 2'd2;
endpackage

// File: rtl/act_ser_buf.sv
// Two-entry FIFO of wide activation vectors; caller guarantees no push when full
// without a pop, and no pop when empty.
module act_ser_buf
  import act_ser_pkg::*;
#(
  parameter int W = IN_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output buf_cnt_t     count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + buf_cnt_t'(1);
        2'b01:   count <= count - buf_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Vector storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/act_out_serializer.sv
// Serializes wide accelerator output vectors into OUT_W beats, LSB slice first.
// Optional frame marker out_last is built when ACT_SER_TLAST_EN is defined.
module act_out_serializer
  import act_ser_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAME_VECS = 49
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             overflow,
  output buf_cnt_t         buf_count
`ifdef ACT_SER_TLAST_EN
  ,
  output logic             out_last
`endif
);

  localparam int        NBEATS    = IN_W / OUT_W;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(NBEATS - 1);

  logic [IN_W-1:0] head;
  beat_idx_t       beat;
  logic            full;
  logic            xfer;
  logic            pop;
  logic            push;

  assign full = (buf_count == BUF_DEPTH);
  assign xfer = out_valid && out_ready;
  assign pop  = xfer && (beat == LAST_BEAT);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push = in_valid && (!full || pop);

  act_ser_buf #(
    .W (IN_W)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .push_data (in_data),
    .head      (head),
    .count     (buf_count)
  );

  assign out_valid = (buf_count != '0);
  assign out_data  = out_valid ? head[int'(beat)*OUT_W +: OUT_W] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat <= '0;
    end else if (xfer) begin
      beat <= pop ? '0 : beat + beat_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (in_valid && full && !pop) begin
      overflow <= 1'b1;
    end
  end

`ifdef ACT_SER_TLAST_EN
  localparam int               VC_W     = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1;
  localparam logic [VC_W-1:0]  LAST_VEC = VC_W'(FRAME_VECS - 1);

  logic [VC_W-1:0] vec_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vec_cnt <= '0;
    end else if (pop) begin
      vec_cnt <= (vec_cnt == LAST_VEC) ? '0 : vec_cnt + VC_W'(1);
    end
  end

  assign out_last = out_valid && (beat == LAST_BEAT) && (vec_cnt == LAST_VEC);
`endif

endmodule
